a5_keystream_gen: RTL and testbench

//  A5/1 keystream sequencer. Drives three A5 LFSR registers through the load/clk_en/d interface:

---
 rtl/a5_keystream_gen_pkg.sv | 50 +++++
 rtl/a5_keystream_gen_if.sv | 18 +
 rtl/a5_ks_packer.sv | 104 ++++++++++
 rtl/a5_lfsr.sv | 52 +++++
 rtl/a5_keystream_gen.sv | 178 +++++++++++++++++
 tb/tb_a5_keystream_gen.sv | 275 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/a5_keystream_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a5_pkg
//  Description : Shared A5/1 constants: register geometry, tap masks,
//                clock-bit positions, sequencer state codes and run defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package a5_pkg;

    // Register lengths
    localparam int c_r1_len = 19;
    localparam int c_r2_len = 22;
    localparam int c_r3_len = 23;

    // Feedback tap masks (bit i set means bit i feeds the parity)
    localparam logic [c_r1_len-1:0] c_r1_taps = 19'h07_2000; // 13,16,17,18
    localparam logic [c_r2_len-1:0] c_r2_taps = 22'h30_0000; // 20,21
    localparam logic [c_r3_len-1:0] c_r3_taps = 23'h70_0080; // 7,20,21,22

    // Majority clocking bit positions
    localparam int c_r1_clk_bit = 8;
    localparam int c_r2_clk_bit = 10;
    localparam int c_r3_clk_bit = 10;

    // Default run geometry
    localparam int c_key_bits   = 64;
    localparam int c_frame_bits = 22;
    localparam int c_mix_cycles = 100;
    localparam int c_ks_bits    = 228;

    // Sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_clr   = 3'd1;
    localparam state_t c_st_key   = 3'd2;
    localparam state_t c_st_frame = 3'd3;
    localparam state_t c_st_mix   = 3'd4;
    localparam state_t c_st_ks    = 3'd5;
    localparam state_t c_st_drain = 3'd6;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/a5_keystream_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : a5_keystream_gen_if
//  Description : Keystream word stream (valid/ready with last qualifier).
//  Revision    : 1.0 - initial release
// ============================================================================
interface a5_keystream_gen_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] ks_data;
    logic             ks_valid;
    logic             ks_ready;
    logic             ks_last;

    modport master (output ks_data, output ks_valid, output ks_last, input ks_ready);
    modport slave  (input ks_data, input ks_valid, input ks_last, output ks_ready);
endinterface
`default_nettype wire

// File: rtl/a5_ks_packer.sv
`default_nettype none
// ============================================================================
//  Module      : a5_ks_packer
//  Description : Packs serial keystream bits MSB-first into words. A bit
//                accumulator feeds a single output register on a valid/ready
//                stream. The last bit closes the word early (zero padding in
//                the low bits) and tags it with ks_last. o_stall tells the
//                sequencer a finished word has nowhere to go this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module a5_ks_packer #(
    parameter int OUT_W = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          i_clear,
    input  wire logic          i_bit_valid,
    input  wire logic          i_bit,
    input  wire logic          i_bit_last,
    output logic               o_stall,
    output logic               o_last_xfer,
    a5_keystream_gen_if.master ks
);

    localparam int c_pos_w = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [OUT_W-1:0]   r_acc;
    logic [OUT_W-1:0]   r_data;
    logic [c_pos_w-1:0] r_pos;
    logic               r_acc_full;
    logic               r_acc_last;
    logic               r_valid;
    logic               r_last;

    logic [OUT_W-1:0]   w_acc_base;
    logic [OUT_W-1:0]   w_acc_nxt;
    logic [c_pos_w-1:0] w_pos_base;
    logic [c_pos_w-1:0] w_idx;
    logic               w_out_free;
    logic               w_xfer;

    assign w_out_free  = !r_valid || ks.ks_ready;
    assign w_xfer      = r_acc_full && w_out_free;
    assign o_stall     = r_acc_full && !w_out_free;
    assign o_last_xfer = r_valid && r_last && ks.ks_ready;

    // A word leaving the accumulator this cycle frees it for the incoming bit
    always_comb begin
        w_acc_base         = w_xfer ? '0 : r_acc;
        w_pos_base         = w_xfer ? '0 : r_pos;
        w_idx              = c_pos_w'(OUT_W - 1) - w_pos_base;
        w_acc_nxt          = w_acc_base;
        w_acc_nxt[w_idx]   = i_bit;
    end

    // Accumulator and output register; the output only loads when free, so
    // data stays put while valid is waiting for ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r_pos      <= '0;
            r_acc_full <= 1'b0;
            r_acc_last <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else if (i_clear) begin
            r_acc      <= '0;
            r_pos      <= '0;
            r_acc_full <= 1'b0;
            r_acc_last <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            if (ks.ks_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            if (w_xfer) begin
                r_data  <= r_acc;
                r_valid <= 1'b1;
                r_last  <= r_acc_last;
            end
            if (i_bit_valid) begin
                r_acc      <= w_acc_nxt;
                r_pos      <= w_pos_base + 1'b1;
                r_acc_full <= (w_pos_base == c_pos_w'(OUT_W - 1)) || i_bit_last;
                r_acc_last <= i_bit_last;
            end else if (w_xfer) begin
                r_acc      <= '0;
                r_pos      <= '0;
                r_acc_full <= 1'b0;
                r_acc_last <= 1'b0;
            end
        end
    end

    assign ks.ks_data  = r_data;
    assign ks.ks_valid = r_valid;
    assign ks.ks_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/a5_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : a5_lfsr
//  Description : One A5 shift register. load clears it; clk_en shifts left
//                with (tap parity ^ d) entering bit 0. The MSB of the next
//                state is exported so the keystream bit can be taken from
//                the post-clock contents in the same cycle the shift happens.
//  Revision    : 1.0 - initial release
// ============================================================================
module a5_lfsr #(
    parameter int             LEN      = 19,
    parameter logic [LEN-1:0] TAP_MASK = '0,
    parameter int             CLK_BIT  = 8
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_load,
    input  wire logic i_clk_en,
    input  wire logic i_d,
    output logic      o_clk_bit,
    output logic      o_msb_nxt
);

    logic [LEN-1:0] r_q;
    logic [LEN-1:0] w_q_nxt;
    logic           w_fb;

    // Next-state selection: clear has priority over shifting
    always_comb begin
        w_fb    = ^(r_q & TAP_MASK);
        w_q_nxt = r_q;
        if (i_load) begin
            w_q_nxt = '0;
        end else if (i_clk_en) begin
            w_q_nxt = {r_q[LEN-2:0], w_fb ^ i_d};
        end
    end

    // Register update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign o_clk_bit = r_q[CLK_BIT];
    assign o_msb_nxt = w_q_nxt[LEN-1];

endmodule
`default_nettype wire

// File: rtl/a5_keystream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : a5_keystream_gen
//  Description : A5/1 keystream sequencer. Clears the three LFSRs, loads key
//                then frame serially, runs majority-clocked mixing with the
//                output discarded, then streams KS_BITS keystream bits through
//                the word packer. Stalls only in KS under backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module a5_keystream_gen
    import a5_pkg::*;
#(
    parameter int KEY_BITS   = c_key_bits,
    parameter int FRAME_BITS = c_frame_bits,
    parameter int MIX_CYCLES = c_mix_cycles,
    parameter int KS_BITS    = c_ks_bits,
    parameter int OUT_W      = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  start,
    input  wire logic                  abort,
    input  wire logic [KEY_BITS-1:0]   key,
    input  wire logic [FRAME_BITS-1:0] frame,
    output logic                       busy,
    output logic                       done,
    a5_keystream_gen_if.master         ks
);

    localparam int c_cnt_max = max2(max2(KEY_BITS, FRAME_BITS), max2(MIX_CYCLES, KS_BITS));
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [KEY_BITS-1:0] r_key;
    logic [FRAME_BITS-1:0] r_frame;
    logic                r_busy;
    logic                r_done;

    logic       w_load;
    logic       w_d;
    logic [2:0] w_en;
    logic [2:0] w_maj_en;
    logic       w_maj;
    logic       w_cb1, w_cb2, w_cb3;
    logic       w_msb1, w_msb2, w_msb3;
    logic       w_stall;
    logic       w_last_xfer;
    logic       w_bit_valid;

    assign w_maj       = maj3(w_cb1, w_cb2, w_cb3);
    assign w_maj_en    = {w_cb3 == w_maj, w_cb2 == w_maj, w_cb1 == w_maj};
    assign w_bit_valid = (r_state == c_st_ks) && !w_stall;

    // LFSR control per state; key/frame bits are taken LSB first from shifters
    always_comb begin
        w_load = 1'b0;
        w_d    = 1'b0;
        w_en   = 3'b000;
        case (r_state)
            c_st_clr:   w_load = 1'b1;
            c_st_key:   begin w_en = 3'b111; w_d = r_key[0];   end
            c_st_frame: begin w_en = 3'b111; w_d = r_frame[0]; end
            c_st_mix:   w_en = w_maj_en;
            c_st_ks:    if (!w_stall) w_en = w_maj_en;
            default:    ;
        endcase
    end

    // Sequencer: state, shared down-counter, captured operands, busy/done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_key   <= '0;
            r_frame <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= c_st_idle;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start) begin
                            r_key   <= key;
                            r_frame <= frame;
                            r_busy  <= 1'b1;
                            r_state <= c_st_clr;
                        end
                    end
                    c_st_clr: begin
                        r_cnt   <= c_cnt_w'(KEY_BITS - 1);
                        r_state <= c_st_key;
                    end
                    c_st_key: begin
                        r_key <= r_key >> 1;
                        if (r_cnt == '0) begin
                            r_cnt   <= c_cnt_w'(FRAME_BITS - 1);
                            r_state <= c_st_frame;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_st_frame: begin
                        r_frame <= r_frame >> 1;
                        if (r_cnt == '0) begin
                            r_cnt   <= c_cnt_w'(MIX_CYCLES - 1);
                            r_state <= c_st_mix;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_st_mix: begin
                        if (r_cnt == '0) begin
                            r_cnt   <= c_cnt_w'(KS_BITS - 1);
                            r_state <= c_st_ks;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_st_ks: begin
                        if (!w_stall) begin
                            if (r_cnt == '0) begin
                                r_state <= c_st_drain;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                    c_st_drain: begin
                        if (w_last_xfer) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_st_idle;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    a5_lfsr #(.LEN(c_r1_len), .TAP_MASK(c_r1_taps), .CLK_BIT(c_r1_clk_bit)) u_r1 (
        .clk(clk), .reset_n(reset_n), .i_load(w_load), .i_clk_en(w_en[0]), .i_d(w_d),
        .o_clk_bit(w_cb1), .o_msb_nxt(w_msb1)
    );

    a5_lfsr #(.LEN(c_r2_len), .TAP_MASK(c_r2_taps), .CLK_BIT(c_r2_clk_bit)) u_r2 (
        .clk(clk), .reset_n(reset_n), .i_load(w_load), .i_clk_en(w_en[1]), .i_d(w_d),
        .o_clk_bit(w_cb2), .o_msb_nxt(w_msb2)
    );

    a5_lfsr #(.LEN(c_r3_len), .TAP_MASK(c_r3_taps), .CLK_BIT(c_r3_clk_bit)) u_r3 (
        .clk(clk), .reset_n(reset_n), .i_load(w_load), .i_clk_en(w_en[2]), .i_d(w_d),
        .o_clk_bit(w_cb3), .o_msb_nxt(w_msb3)
    );

    a5_ks_packer #(.OUT_W(OUT_W)) u_packer (
        .clk(clk),
        .reset_n(reset_n),
        .i_clear(abort),
        .i_bit_valid(w_bit_valid),
        .i_bit(w_msb1 ^ w_msb2 ^ w_msb3),
        .i_bit_last(r_cnt == '0),
        .o_stall(w_stall),
        .o_last_xfer(w_last_xfer),
        .ks(ks)
    );

endmodule
`default_nettype wire

// File: tb/tb_a5_keystream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a5_keystream_gen
//  Description : Scoreboard bench for the A5/1 keystream sequencer. Stimulus
//                pushes the expected 29 words of the reference vector; a
//                negedge monitor pops on every handshake and also watches
//                hold-while-stalled, done timing and done counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_a5_keystream_gen;

    localparam logic [63:0] c_key   = 64'hEFCDAB8967452312;
    localparam logic [21:0] c_frame = 22'h134;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [63:0] key;
    logic [21:0] frame;
    logic        busy;
    logic        done;

    a5_keystream_gen_if #(.OUT_W(8)) ks_bus ();

    a5_keystream_gen #(
        .KEY_BITS(64), .FRAME_BITS(22), .MIX_CYCLES(100), .KS_BITS(228), .OUT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .key(key), .frame(frame), .busy(busy), .done(done), .ks(ks_bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_done   = 0;
    int n_words  = 0;
    int done0    = 0;
    int t_start  = 0;
    int t_first  = 0;
    bit lat_arm  = 1'b0;
    bit rand_ready  = 1'b0;
    bit ready_level = 1'b1;

    logic [119:0] dl_hex;
    logic [119:0] ul_hex;
    logic [227:0] ks_ref;
    logic [8:0]   exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Single driver for ks_ready
    always @(posedge clk) begin
        #1;
        ks_bus.ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_ref();
        dl_hex = 120'h534EAA582FE8151AB6E1855A728C00;
        ul_hex = 120'h24FD35A35D5FB6526D32F906DF1AC0;
        for (int k = 0; k < 114; k++) begin
            ks_ref[k]       = dl_hex[119-k];
            ks_ref[114 + k] = ul_hex[119-k];
        end
    endtask

    function automatic logic [7:0] ref_word(input int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (8 * w + i < 228) r[7-i] = ks_ref[8 * w + i];
        return r;
    endfunction

    // Monitor / scoreboard
    bit         prev_valid = 1'b0;
    bit         prev_ready = 1'b0;
    bit         prev_abort = 1'b0;
    bit         prev_hs_last = 1'b0;
    logic [7:0] prev_data  = '0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset_n) begin
            prev_valid   = 1'b0;
            prev_hs_last = 1'b0;
        end else begin
            if (prev_valid && !prev_ready && !prev_abort) begin
                check("hold_valid", ks_bus.ks_valid, 1);
                check("hold_data", ks_bus.ks_data, prev_data);
            end
            if (prev_hs_last && !prev_abort) begin
                check("done_after_last", done, 1);
                check("busy_low_at_done", busy, 0);
            end
            if (done) n_done++;
            if (lat_arm && ks_bus.ks_valid) begin
                t_first = cyc;
                lat_arm = 1'b0;
            end
            if (ks_bus.ks_valid && ks_bus.ks_ready && !abort) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %02h, required no word", ks_bus.ks_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", ks_bus.ks_data, e[7:0]);
                    check("word_last", ks_bus.ks_last, e[8]);
                end
                if (ks_bus.ks_last) check("busy_before_done", busy, 1);
            end
            prev_valid   = ks_bus.ks_valid;
            prev_ready   = ks_bus.ks_ready;
            prev_data    = ks_bus.ks_data;
            prev_abort   = abort;
            prev_hs_last = ks_bus.ks_valid && ks_bus.ks_ready && ks_bus.ks_last;
        end
    end

    task automatic start_run(input logic [63:0] k, input logic [21:0] f);
        for (int w = 0; w < 29; w++) exp_q.push_back({(w == 28), ref_word(w)});
        n_words = 0;
        done0   = n_done;
        lat_arm = 1'b1;
        @(posedge clk); #1;
        key = k; frame = f; start = 1'b1;
        @(posedge clk); #1;
        t_start = cyc;
        start = 1'b0; key = '0; frame = '0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
    endtask

    task automatic pulse_start(input logic [63:0] k);
        @(posedge clk); #1;
        key = k; start = 1'b1;
        @(posedge clk); #1;
        key = '0; start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        #1;
        check("done_seen", got, 1);
    endtask

    task automatic wait_valid(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (ks_bus.ks_valid) got = 1'b1;
        end
        check("valid_seen", got, 1);
    endtask

    task automatic run_full();
        start_run(c_key, c_frame);
        wait_done(4000);
        check("words_per_run", n_words, 29);
        check("queue_drained", exp_q.size(), 0);
        check("done_count", n_done - done0, 1);
        check("first_valid_latency", t_first - t_start, 196);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, ks_bus.ks_valid, 0);
        check({tag, "_last"}, ks_bus.ks_last, 0);
        check({tag, "_data"}, ks_bus.ks_data, 0);
    endtask

    initial begin
        build_ref();
        start = 1'b0; abort = 1'b0; key = '0; frame = '0; reset_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset_n = 1'b1;

        // 1 + 6: known answer with ready=1, latency and done timing
        run_full();

        // 2: random backpressure
        rand_ready = 1'b1;
        run_full();
        rand_ready = 1'b0;

        // 3: start during MIX and KS is ignored
        start_run(c_key, c_frame);
        while (cyc < t_start + 150) @(posedge clk);
        pulse_start(64'h0123456789ABCDEF);
        while (cyc < t_start + 250) @(posedge clk);
        pulse_start(64'hFFFF0000FFFF0000);
        wait_done(4000);
        check("ign_words", n_words, 29);
        check("ign_queue", exp_q.size(), 0);
        check("ign_done_count", n_done - done0, 1);
        repeat (5) @(negedge clk);
        check("ign_idle_after", busy, 0);

        // 4a: abort during KEY
        start_run(c_key, c_frame);
        repeat (20) @(posedge clk);
        pulse_abort();
        check("abort_key_busy", busy, 0);
        check("abort_key_valid", ks_bus.ks_valid, 0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        check("abort_key_no_done", n_done - done0, 0);

        // 4b: abort during KS while a word is waiting
        ready_level = 1'b0;
        start_run(c_key, c_frame);
        wait_valid(400);
        pulse_abort();
        check("abort_ks_valid", ks_bus.ks_valid, 0);
        check("abort_ks_last", ks_bus.ks_last, 0);
        check("abort_ks_busy", busy, 0);
        exp_q.delete();
        repeat (300) @(negedge clk);
        check("abort_ks_no_done", n_done - done0, 0);
        check("abort_ks_still_idle", ks_bus.ks_valid, 0);
        ready_level = 1'b1;
        repeat (2) @(posedge clk);
        run_full();

        // 5: reset mid-KS
        start_run(c_key, c_frame);
        for (int i = 0; i < 600 && n_words < 5; i++) @(negedge clk);
        check("pre_reset_words", (n_words >= 5), 1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        run_full();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
